// File: rtl/l2_arbiter_ctrl.sv
// Arbiter sharing one L2 line port between the I-cache and D-cache.
// Round-robin on contention; grant is held until the L2 responds, then a one-cycle response pulse.
module l2_arbiter_ctrl #(
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iread,
  input  logic [31:0]           iaddr,
  output logic [LINE_WIDTH-1:0] irdata,
  output logic                  iresp,
  input  logic                  dread,
  input  logic                  dwrite,
  input  logic [31:0]           daddr,
  input  logic [LINE_WIDTH-1:0] dwdata,
  output logic [LINE_WIDTH-1:0] drdata,
  output logic                  dresp,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic                    last, last_next;
  logic [31:0]             addr_q, addr_next;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_next;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_next;
  logic                    wr_q, wr_next;
  logic                    dreq;
  logic                    mem_read_next, mem_write_next, iresp_next, dresp_next;

  assign dreq = dread | dwrite;

  // Next-state and datapath capture decisions.
  always_comb begin
    state_next = state;
    last_next  = last;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    rdata_next = rdata_q;
    wr_next    = wr_q;
    case (state)
      IDLE: begin
        // last=1 means D was served most recently, so I wins a tie.
        if (iread && (!dreq || last)) begin
          state_next = SERVE_I;
          addr_next  = iaddr;
          wr_next    = 1'b0;
        end else if (dreq) begin
          state_next = SERVE_D;
          addr_next  = daddr;
          wdata_next = dwdata;
          wr_next    = dwrite;
        end else begin
          state_next = IDLE;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          rdata_next = mem_rdata;
          last_next  = 1'b0;
          state_next = RESP_I;
        end else begin
          state_next = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          if (!wr_q) begin
            rdata_next = mem_rdata;
          end else begin
            rdata_next = rdata_q;
          end
          last_next  = 1'b1;
          state_next = RESP_D;
        end else begin
          state_next = SERVE_D;
        end
      end
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and pulses are decoded from the upcoming state so they leave a flop.
  always_comb begin
    mem_read_next  = (state_next == SERVE_I) || ((state_next == SERVE_D) && !wr_next);
    mem_write_next = (state_next == SERVE_D) && wr_next;
    iresp_next     = (state_next == RESP_I);
    dresp_next     = (state_next == RESP_D);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      addr_q    <= 32'd0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      iresp     <= 1'b0;
      dresp     <= 1'b0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      rdata_q   <= rdata_next;
      wr_q      <= wr_next;
      mem_read  <= mem_read_next;
      mem_write <= mem_write_next;
      iresp     <= iresp_next;
      dresp     <= dresp_next;
    end
  end

  assign irdata    = rdata_q;
  assign drdata    = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_l2_arbiter_ctrl.sv
// Self-checking bench for l2_arbiter_ctrl: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l2_arbiter_ctrl;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          iread, dread, dwrite, mem_resp;
  logic [31:0]   iaddr, daddr;
  logic [LW-1:0] dwdata, mem_rdata;
  logic [LW-1:0] irdata, drdata, mem_wdata;
  logic          iresp, dresp, mem_read, mem_write;
  logic [31:0]   mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: transaction phase (0 free, 1 L2 busy, 2 answering), owner, fairness memory.
  int            m_phase;
  bit            m_own_d;
  bit            m_last_d;
  bit            m_wr;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wdata, m_rdata;

  // Results of the most recent txn() call.
  int            t_hi;
  logic [31:0]   t_addr;
  logic [LW-1:0] t_wd;
  bit            t_rd, t_wr, t_ir, t_dr;

  l2_arbiter_ctrl #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .iread(iread), .iaddr(iaddr), .irdata(irdata), .iresp(iresp),
    .dread(dread), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dresp(dresp),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_own_d  = 1'b0;
    m_last_d = 1'b1;
    m_wr     = 1'b0;
    m_addr   = 32'd0;
    m_wdata  = '0;
    m_rdata  = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently presented.
  task automatic model_edge();
    bit iq, dq;
    iq = iread;
    dq = dread | dwrite;
    if (rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (iq || dq) begin
        m_own_d = dq && !(iq && m_last_d);
        m_phase = 1;
        if (m_own_d) begin
          m_addr  = daddr;
          m_wdata = dwdata;
          m_wr    = dwrite;
        end else begin
          m_addr = iaddr;
        end
      end
    end else if (m_phase == 1) begin
      if (mem_resp) begin
        if (!(m_own_d && m_wr)) m_rdata = mem_rdata;
        m_last_d = m_own_d;
        m_phase  = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    bit busy, wr_now;
    busy   = (m_phase == 1);
    wr_now = busy && m_own_d && m_wr;
    chk("mem_read",  mem_read,  busy && !wr_now);
    chk("mem_write", mem_write, wr_now);
    chk("iresp",     iresp,     (m_phase == 2) && !m_own_d);
    chk("dresp",     dresp,     (m_phase == 2) && m_own_d);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("irdata",    irdata,    m_rdata);
    chk("drdata",    drdata,    m_rdata);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Run the current request to completion; the L2 answers on the lat-th strobe cycle.
  task automatic txn(input int lat, input logic [LW-1:0] rd, input bit garble, input bit drop_i);
    bit done;
    done = 1'b0;
    t_hi = 0; t_addr = 32'd0; t_wd = '0;
    t_rd = 1'b0; t_wr = 1'b0; t_ir = 1'b0; t_dr = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      step();
      mem_resp = 1'b0;
      if (iresp || dresp) begin
        t_ir = iresp;
        t_dr = dresp;
        done = 1'b1;
      end else if (mem_read || mem_write) begin
        t_hi++;
        t_addr = mem_addr;
        t_wd   = mem_wdata;
        t_rd   = t_rd | mem_read;
        t_wr   = t_wr | mem_write;
        if (t_hi == 1 && garble) begin
          daddr  = $urandom;
          dwdata = rand_line();
        end
        if (t_hi == 1 && drop_i) iread = 1'b0;
        if (t_hi == lat) begin
          mem_resp  = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: no response pulse within 60 cycles");
    end
  endtask

  initial begin
    logic [LW-1:0] a5_line, wline;
    rst = 1'b1; iread = 1'b0; dread = 1'b0; dwrite = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dwdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    a5_line = {32{8'hA5}};
    model_reset();

    // Reset state.
    step();
    step();
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_irdata", irdata, '0);
    rst = 1'b0;
    step();

    // Single I read, L2 latency 3.
    iread = 1'b1; iaddr = 32'h0000_1000;
    txn(3, a5_line, 1'b0, 1'b0);
    chk("i_hi_cycles", t_hi, 3);
    chk("i_addr", t_addr, 32'h0000_1000);
    chk("i_read_seen", t_rd, 1'b1);
    chk("i_iresp", t_ir, 1'b1);
    chk("i_no_dresp", t_dr, 1'b0);
    chk("i_irdata", irdata, a5_line);
    iread = 1'b0;
    step();
    chk("i_pulse_len", iresp, 1'b0);

    // D write-back with inputs garbled after grant.
    wline = {8{32'h1234_5678}};
    dwrite = 1'b1; daddr = 32'h0000_2000; dwdata = wline;
    txn(4, rand_line(), 1'b1, 1'b0);
    chk("w_addr", t_addr, 32'h0000_2000);
    chk("w_wdata", t_wd, wline);
    chk("w_write_seen", t_wr, 1'b1);
    chk("w_no_read", t_rd, 1'b0);
    chk("w_dresp", t_dr, 1'b1);
    chk("w_hi_cycles", t_hi, 4);
    dwrite = 1'b0;
    step();
    chk("w_pulse_len", dresp, 1'b0);

    // Contention from reset: strict alternation starting with I.
    rst = 1'b1;
    step();
    rst = 1'b0;
    iread = 1'b1; dread = 1'b1; iaddr = 32'h0000_0100; daddr = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      txn(1 + k % 3, rand_line(), 1'b0, 1'b0);
      chk("alt_dresp", t_dr, (k % 2 == 1));
      chk("alt_iresp", t_ir, (k % 2 == 0));
      chk("alt_addr", t_addr, (k % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
    end
    iread = 1'b0; dread = 1'b0;
    step();
    step();

    // Asynchronous reset during a D write.
    dwrite = 1'b1; daddr = 32'h0000_3000; dwdata = rand_line();
    step();
    step();
    chk("pre_rst_mem_write", mem_write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_mem_write", mem_write, 1'b0);
    compare_all();
    dwrite = 1'b0;
    step();
    rst = 1'b0;
    iread = 1'b1; dread = 1'b1; iaddr = 32'h0000_0400; daddr = 32'h0000_0500;
    txn(2, rand_line(), 1'b0, 1'b0);
    chk("post_rst_i_first", t_ir, 1'b1);
    chk("post_rst_addr", t_addr, 32'h0000_0400);
    iread = 1'b0;
    txn(2, rand_line(), 1'b0, 1'b0);
    chk("post_rst_d_next", t_dr, 1'b1);
    dread = 1'b0;
    step();

    // Spurious mem_resp in IDLE, then an I read dropped mid-transaction.
    mem_resp = 1'b1; mem_rdata = rand_line();
    step();
    mem_resp = 1'b0;
    chk("spur_no_iresp", iresp, 1'b0);
    chk("spur_no_read", mem_read, 1'b0);
    step();
    iread = 1'b1; iaddr = 32'h0000_0600;
    txn(3, rand_line(), 1'b0, 1'b1);
    chk("drop_iresp", t_ir, 1'b1);
    chk("drop_addr", t_addr, 32'h0000_0600);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      iread     = ($urandom % 3) != 0;
      dread     = ($urandom % 2) != 0;
      dwrite    = ($urandom % 3) == 0;
      iaddr     = $urandom;
      daddr     = $urandom;
      dwdata    = rand_line();
      mem_resp  = ($urandom % 3) == 0;
      mem_rdata = rand_line();
      rst       = ($urandom % 150) == 0;
      step();
      chk("excl_strobes", mem_read & mem_write, 1'b0);
      chk("excl_resp", iresp & dresp, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l2_arbiter_ctrl.md
Name: l2_arbiter_ctrl

Overview:
- Registered, stateful arbiter sharing one L2/memory line port between the I-cache and the D-cache.
- Grants one requester at a time and latches its address and write data at grant.
- Holds the grant until the L2 responds, then returns the line with a clean one-cycle response pulse.
- Fairness: round-robin on contention, I-cache wins ties out of reset. Sits between both L1 caches and the L2 cache.

Parameters:
- LINE_WIDTH, 256, cache line width in bits on every data bus.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- iread  input  1  I-cache line read request, level, held until iresp.
- iaddr  input  32  I-cache line address.
- irdata  output  LINE_WIDTH  line returned to I-cache, valid with iresp.
- iresp  output  1  one-cycle completion pulse to I-cache.
- dread  input  1  D-cache line read request, level.
- dwrite  input  1  D-cache line write-back request, level.
- daddr  input  32  D-cache line address.
- dwdata  input  LINE_WIDTH  D-cache write-back line.
- drdata  output  LINE_WIDTH  line returned to D-cache, valid with dresp.
- dresp  output  1  one-cycle completion pulse to D-cache.
- mem_rdata  input  LINE_WIDTH  L2 read data, valid with mem_resp.
- mem_resp  input  1  L2 completion, one cycle per transaction.
- mem_read  output  1  L2 read strobe, level, held until mem_resp.
- mem_write  output  1  L2 write strobe, level, held until mem_resp.
- mem_addr  output  32  latched address of the granted request.
- mem_wdata  output  LINE_WIDTH  latched write data of the granted request.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D. Registers: state, last (0=I, 1=D), addr_q, wdata_q, wr_q, rdata_q.
- Reset (async, rst=1): state=IDLE, last=1 (so I wins the first tie), all registers 0.
  - All outputs read 0 during and after reset until a grant: mem_read, mem_write, iresp, dresp, irdata, drdata, mem_addr, mem_wdata.
- IDLE:
  - ireq=iread; dreq=dread|dwrite.
  - Only ireq -> SERVE_I. Only dreq -> SERVE_D.
  - Both -> SERVE_D if last=0, else SERVE_I.
  - On grant: latch addr_q from the granted address; latch wdata_q=dwdata and wr_q=dwrite (for D).
  - If dread and dwrite are both set, it is treated as a write.
- SERVE_I:
  - mem_read=1, mem_addr=addr_q.
  - On mem_resp: rdata_q<=mem_rdata, last<=0, go to RESP_I.
- SERVE_D:
  - mem_read=~wr_q, mem_write=wr_q, mem_addr=addr_q, mem_wdata=wdata_q.
  - On mem_resp: capture rdata_q (reads only), last<=1, go to RESP_D.
- RESP_I: iresp=1 for exactly one cycle, irdata=rdata_q, mem strobes 0, then IDLE.
- RESP_D: dresp=1 for exactly one cycle, drdata=rdata_q (don't-care after writes), mem strobes 0, then IDLE.
- irdata/drdata are driven from rdata_q at all times; they are only meaningful in the response cycle.
- Latency:
  - Request sampled in IDLE at edge N; mem strobe visible in cycle N+1.
  - mem_resp at edge M; iresp/dresp high in cycle M+1.
  - Minimum L1 turnaround = L2 latency + 2 cycles. Back-to-back grants are separated by one RESP cycle plus one IDLE cycle.
- Input changes while in SERVE_*: requests, addresses and data are ignored; the latched values drive the L2.
- Requester drops its request mid-transaction: the L2 transaction still completes and the response pulse is still issued. Requesters must hold their request until the response.
- mem_resp outside SERVE_* is ignored.
- Ports are mutually exclusive by construction:
  - mem_read and mem_write are never both high.
  - iresp and dresp are never both high.
  - No strobe is asserted in IDLE or RESP_*.
- rst asserted mid-transaction: immediate return to IDLE and strobes drop; the pending requester gets no response.

Test Plan:
- Reset, then iread=1, iaddr=0x0000_1000; L2 responds after 3 cycles with rdata=0xA5..A5 -> mem_read high 3 cycles with mem_addr=0x1000; iresp pulses one cycle later with irdata=0xA5..A5; dresp stays 0.
- dwrite=1, daddr=0x2000, dwdata=0x1234..; daddr/dwdata changed to garbage after grant -> mem_write=1 with mem_addr=0x2000 and the original wdata until mem_resp; mem_read never high; dresp single pulse.
- iread and dread asserted together out of reset and held -> I served first (mem_addr=iaddr), then D (mem_addr=daddr); third contention grants I again (alternation).
- Continuous iread plus dread for 10 transactions -> grants strictly alternate I,D,I,D; no requester is served twice in a row while the other waits.
- rst pulsed while in SERVE_D with mem_write=1 -> mem_write drops asynchronously; no dresp; next iread is served normally with last reset (I wins the tie).
- Spurious mem_resp in IDLE, and iread dropped mid-SERVE_I -> no state change in IDLE; the iresp pulse still occurs after the real mem_resp.
